// File: rtl/onehot_encoder.sv
// onehot_encoder
//   Serializes a one-hot / multi-hot request vector into a stream of binary
//   indices, lowest set bit first, one index per output handshake.
//
//   Optional build macro: ONEHOT_ENCODER_STRICT_EN
//     defined   -> vectors with more than one set bit are rejected (err pulse)
//     undefined -> multi-hot vectors are serialized bit by bit
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   din is valid
//     in_ready   block can accept din
//     din        request vector, bit k means register k
//     out_valid  dout is valid
//     out_ready  consumer accepts dout
//     dout       binary index of the lowest pending bit
//     out_last   dout is the final index of the current vector
//     err        one-cycle pulse after an accepted vector was rejected
//
//   state | meaning
//   IDLE  | no pending bits, waiting for a vector
//   BUSY  | pending holds at least one bit, presenting its lowest index
module onehot_encoder #(
    parameter int N    = 32,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] dout,
    output logic            out_last,
    output logic            err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [N-1:0]    pending, pending_nxt;
    logic            err_nxt;
    logic [IDXW-1:0] low_idx;
    logic            pend_single;
    logic            out_hs;
    logic            accept;
    logic            din_bad;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    assign pend_single = (pending != '0) && ((pending & (pending - ONE)) == '0);

    assign out_valid = (state == BUSY);
    assign dout      = out_valid ? low_idx : '0;
    assign out_last  = out_valid & pend_single;
    assign out_hs    = out_valid & out_ready;

    // rst_n gates in_ready so it reads 0 throughout reset, independent of clk.
    assign in_ready = rst_n & ((state == IDLE) | (out_hs & out_last));
    assign accept   = in_valid & in_ready;

`ifdef ONEHOT_ENCODER_STRICT_EN
    assign din_bad = (din == '0) || ((din & (din - ONE)) != '0);
`else
    assign din_bad = (din == '0);
`endif

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        err_nxt     = 1'b0;
        if (out_hs) begin
            // Clear the bit just delivered (lowest set bit).
            pending_nxt = pending & (pending - ONE);
            if (out_last) begin
                state_nxt = IDLE;
            end
        end
        if (accept) begin
            if (din_bad) begin
                err_nxt = 1'b1;
            end else begin
                pending_nxt = din;
                state_nxt   = BUSY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_encoder.sv
// tb_onehot_encoder
//   Directed bench for onehot_encoder: reset, single/multi-hot serialization,
//   backpressure hold, zero-vector error, back-to-back accept, mid-vector
//   reset, and the strict/non-strict multi-hot behaviour.
module tb_onehot_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  dout;
    logic        out_last;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    onehot_encoder #(.N(32), .IDXW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        din       = d;
        out_ready = r;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] d,
                           input logic l);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".dout"},      32'(dout),      32'(d));
        chk({tag, ".out_last"},  32'(out_last),  32'(l));
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk_out("rst", 1'b0, 5'd0, 1'b0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Single one-hot vector.
        drive(1'b1, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk_out("oh1", 1'b1, 5'd0, 1'b1);
        chk("oh1.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("oh1.idle", 1'b0, 5'd0, 1'b0);

`ifndef ONEHOT_ENCODER_STRICT_EN
        // Multi-hot serialization, 0 -> 4 -> 31.
        drive(1'b1, 32'h8000_0011, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk_out("mh.b0", 1'b1, 5'd0, 1'b0);
        chk("mh.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_out("mh.b4", 1'b1, 5'd4, 1'b0);
        tick();
        chk_out("mh.b31", 1'b1, 5'd31, 1'b1);
        tick();
        chk_out("mh.idle", 1'b0, 5'd0, 1'b0);

        // Backpressure after the first handshake holds index 4.
        drive(1'b1, 32'h8000_0011, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk_out("bp.b0", 1'b1, 5'd0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_out("bp.hold", 1'b1, 5'd4, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        chk_out("bp.b4", 1'b1, 5'd4, 1'b0);
        tick();
        chk_out("bp.b31", 1'b1, 5'd31, 1'b1);
        tick();
        chk_out("bp.idle", 1'b0, 5'd0, 1'b0);
`else
        // Strict build: multi-hot vector rejected.
        drive(1'b1, 32'h8000_0011, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("smh.err", 32'(err), 32'd1);
        chk_out("smh", 1'b0, 5'd0, 1'b0);
        tick();
        chk("smh.err_end", 32'(err), 32'd0);
        chk_out("smh.idle", 1'b0, 5'd0, 1'b0);
`endif

        // Zero vector: one-cycle err, no output, in_ready stays high.
        drive(1'b1, 32'h0, 1'b1);
        chk("zero.in_ready_pre", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("zero.err", 32'(err), 32'd1);
        chk("zero.out_valid", 32'(out_valid), 32'd0);
        chk("zero.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("zero.err_end", 32'(err), 32'd0);
        chk("zero.out_valid_end", 32'(out_valid), 32'd0);
        chk("zero.in_ready_end", 32'(in_ready), 32'd1);

        // New vector accepted during last handshake, no bubble.
        drive(1'b1, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b1, 32'h0000_0004, 1'b1);
        chk_out("b2b.first", 1'b1, 5'd0, 1'b1);
        chk("b2b.in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk_out("b2b.second", 1'b1, 5'd2, 1'b1);
        chk("b2b.err", 32'(err), 32'd0);
        tick();
        chk_out("b2b.idle", 1'b0, 5'd0, 1'b0);

        // Reset mid-vector drops everything.
        drive(1'b1, 32'h0000_0010, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk_out("mrst.busy", 1'b1, 5'd4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("mrst.asserted", 1'b0, 5'd0, 1'b0);
        chk("mrst.in_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_out("mrst.after", 1'b0, 5'd0, 1'b0);
            chk("mrst.ready_after", 32'(in_ready), 32'd1);
            tick();
        end

        // din = 3: strict rejects, default serializes 0 then 1.
        drive(1'b1, 32'h0000_0003, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
`ifdef ONEHOT_ENCODER_STRICT_EN
        chk("d3.err", 32'(err), 32'd1);
        chk_out("d3.none", 1'b0, 5'd0, 1'b0);
        tick();
        chk("d3.err_end", 32'(err), 32'd0);
        chk_out("d3.idle", 1'b0, 5'd0, 1'b0);
`else
        chk("d3.err", 32'(err), 32'd0);
        chk_out("d3.b0", 1'b1, 5'd0, 1'b0);
        tick();
        chk_out("d3.b1", 1'b1, 5'd1, 1'b1);
        tick();
        chk_out("d3.idle", 1'b0, 5'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_encoder.md
ONEHOT_ENCODER -- requirements
Module: onehot_encoder

Interface
REQ-001 SHALL have parameter N, default 32, meaning width of the one-hot/multi-hot input vector (register-file size).
REQ-002 SHALL have parameter IDXW, default 5, meaning index width, equal to ceil(log2(N)).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  din is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept din.
REQ-007 SHALL have port din  input  N  request vector, bit k means register k.
REQ-008 SHALL have port out_valid  output  1  dout is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts dout.
REQ-010 SHALL have port dout  output  IDXW  binary index of the current set bit.
REQ-011 SHALL have port out_last  output  1  dout is the final index of the current vector.
REQ-012 SHALL have port err  output  1  one-cycle pulse when an accepted vector is rejected.

Function
REQ-013 SHALL implement two states, IDLE and BUSY, and hold an N-bit pending register.
REQ-014 SHALL assert in_ready in IDLE, and in BUSY only in a cycle where out_valid, out_ready and out_last are all 1.
REQ-015 SHALL accept din on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL, on accepting a nonzero legal vector, load it into pending and enter BUSY, so out_valid rises the next cycle (latency 1).
REQ-017 SHALL, on accepting din == 0, discard it, stay in or return to IDLE, and pulse err for one cycle.
REQ-018 SHALL drive out_valid = 1 exactly when in BUSY.
REQ-019 SHALL drive dout as the index of the lowest set bit of pending, and out_last = 1 when pending has exactly one set bit.
REQ-020 SHALL, on an output handshake, clear that bit in pending, so the next index appears the following cycle (throughput 1 index/cycle).
REQ-021 SHALL hold dout, out_last and pending stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL, on the last handshake, return to IDLE unless a new vector is accepted in the same cycle.
REQ-023 SHALL, on a same-cycle new-vector accept (REQ-014 case), load the new vector and stay in BUSY with no bubble cycle.
REQ-024 SHALL drive dout = 0 and out_last = 0 when out_valid = 0.
REQ-025 SHALL ignore in_valid and din while in_ready = 0; the upstream SHALL hold them.

Reset
REQ-026 SHALL, while rst_n = 0, force state IDLE, pending = 0, out_valid = 0, dout = 0, out_last = 0, err = 0 and in_ready = 0, independently of clk.
REQ-027 SHALL assert in_ready in the first clk cycle after rst_n deasserts.
REQ-028 SHALL drop any partially serialized vector on reset mid-operation, with no output afterward.

Configuration
REQ-029 SHALL, with macro ONEHOT_ENCODER_STRICT_EN defined, reject an accepted vector with more than one set bit: discard it, stay IDLE, and pulse err for one cycle.
REQ-030 SHALL, without ONEHOT_ENCODER_STRICT_EN, serialize multi-hot vectors per REQ-016 to REQ-023; err then pulses only for din == 0.

Verification
REQ-031 SHALL cover: din=32'h0000_0001, out_ready=1 -> next cycle dout=0, out_last=1; IDLE the cycle after.
REQ-032 SHALL cover: din=32'h8000_0011, out_ready=1 -> dout 0, 4, 31 on consecutive cycles; out_last only with 31.
REQ-033 SHALL cover: same vector, out_ready=0 for 3 cycles after the first handshake -> dout held at 4, out_valid=1 throughout.
REQ-034 SHALL cover: din=0 accepted -> err=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
REQ-035 SHALL cover: din=32'h0000_0004 presented during the last handshake of 32'h0000_0001 -> accepted that cycle; next cycle dout=2 with no gap; and rst_n pulsed low mid-vector -> out_valid=0 immediately and no further output.
REQ-036 SHALL cover: din=32'h0000_0003 -> with ONEHOT_ENCODER_STRICT_EN, err pulse and no output; without it, dout 0 then 1.
